// File: rtl/biquad_cascade_if.sv
// biquad_cascade_if
// Groups the sample handshake, the result port and the coefficient
// programming port of biquad_cascade into one bundle.
//
// Signals:
//   sample_valid  master->slave  sample_in is valid
//   sample_ready  slave->master  block can accept a sample
//   sample_in     master->slave  input sample, signed DATA_W
//   sample_out    slave->master  last computed output, held between results
//   out_valid     slave->master  one-cycle pulse when sample_out updates
//   coef_we       master->slave  write coef_data into the shadow bank
//   coef_stage    master->slave  target stage of a coefficient write
//   coef_sel      master->slave  0=b0 1=b1 2=b2 3=a1 4=a2, 5-7 ignored
//   coef_data     master->slave  coefficient value, signed COEF_W
//   coef_commit   master->slave  request a shadow-to-active copy
//   coef_updated  slave->master  one-cycle pulse when the copy happens
//   state_clear   master->slave  zero all histories (honoured when idle)
interface biquad_cascade_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int STAGES = 4
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic                     sample_valid;
  logic                     sample_ready;
  logic signed [DATA_W-1:0] sample_in;
  logic signed [DATA_W-1:0] sample_out;
  logic                     out_valid;
  logic                     coef_we;
  logic [SW-1:0]            coef_stage;
  logic [2:0]               coef_sel;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_commit;
  logic                     coef_updated;
  logic                     state_clear;

  modport master (
    output sample_valid, sample_in, coef_we, coef_stage, coef_sel,
           coef_data, coef_commit, state_clear,
    input  sample_ready, sample_out, out_valid, coef_updated
  );

  modport slave (
    input  sample_valid, sample_in, coef_we, coef_stage, coef_sel,
           coef_data, coef_commit, state_clear,
    output sample_ready, sample_out, out_valid, coef_updated
  );
endinterface

// File: rtl/biquad_cascade.sv
// biquad_cascade
// Time-multiplexed cascade of STAGES direct-form-I biquad sections sharing
// one multiplier-accumulator. Each stage computes
//   y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2
// in five MAC cycles followed by one writeback cycle that rounds
// (half-up) by FRAC_W bits and reduces the result to DATA_W bits.
// Coefficients are written into a shadow bank and copied to the active
// bank atomically, either immediately when idle or at the end of the
// sample in flight.
//
// Ports:
//   Clk      rising-edge clock
//   Reset_n  synchronous active-low reset
//   bus      biquad_cascade_if.slave (sample handshake, result,
//            coefficient programming, history clear)
//
// Build option:
//   BIQUAD_CASCADE_SAT_EN  defined: stage results saturate to the DATA_W
//                          range; undefined: they wrap (low DATA_W bits).
module biquad_cascade #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int FRAC_W = 14,
  parameter int STAGES = 4
) (
  input logic            Clk,
  input logic            Reset_n,
  biquad_cascade_if.slave bus
);
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC_W);
  localparam logic signed [ACC_W-1:0]  HALF     = ACC_W'(1 << (FRAC_W - 1));
  localparam logic [SW-1:0]            LAST     = SW'(STAGES - 1);

`ifdef BIQUAD_CASCADE_SAT_EN
  localparam logic signed [DATA_W-1:0] MAX_D   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'(MAX_D);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = ACC_W'(MIN_D);
`endif

  // Round half-up: add one half LSB of the output, then floor-shift.
  function automatic logic signed [ACC_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] t;
    t = a + HALF;
    return t >>> FRAC_W;
  endfunction

  function automatic logic signed [DATA_W-1:0] narrow(
    input logic signed [ACC_W-1:0] v
  );
`ifdef BIQUAD_CASCADE_SAT_EN
    if (v > SAT_MAX) return MAX_D;
    if (v < SAT_MIN) return MIN_D;
`endif
    return DATA_W'(v);
  endfunction

  logic [1:0]               state;
  logic [SW-1:0]            stage;
  logic [2:0]               k;
  logic                     pending;

  logic signed [COEF_W-1:0] active [STAGES][5];
  logic signed [COEF_W-1:0] shadow [STAGES][5];
  logic signed [DATA_W-1:0] x1 [STAGES];
  logic signed [DATA_W-1:0] x2 [STAGES];
  logic signed [DATA_W-1:0] y1 [STAGES];
  logic signed [DATA_W-1:0] y2 [STAGES];

  // Input of the stage being computed; after the last writeback it holds
  // the cascade output.
  logic signed [DATA_W-1:0] xcur;
  logic signed [ACC_W-1:0]  acc;

  logic signed [DATA_W-1:0] op;
  logic signed [COEF_W-1:0] cf;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  r_full;
  logic signed [DATA_W-1:0] r;
  logic                     accept;
  logic                     copy;

  assign bus.sample_ready = (state == IDLE) && Reset_n;
  assign accept           = bus.sample_valid && bus.sample_ready;

  // A commit arriving during DONE is merged into the copy made there.
  assign copy = ((state == IDLE) && bus.coef_commit) ||
                ((state == DONE) && (pending || bus.coef_commit));

  always_comb begin
    op = xcur;
    cf = active[stage][k];
    case (k)
      3'd1:    op = x1[stage];
      3'd2:    op = x2[stage];
      3'd3:    op = y1[stage];
      3'd4:    op = y2[stage];
      default: op = xcur;
    endcase
  end

  assign prod   = PROD_W'(op) * PROD_W'(cf);
  assign r_full = round_shift(acc);
  assign r      = narrow(r_full);

  // ---- control, coefficient banks and histories ----
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state            <= IDLE;
      stage            <= '0;
      k                <= '0;
      pending          <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.coef_updated <= 1'b0;
      bus.sample_out   <= '0;
      for (int s = 0; s < STAGES; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
        for (int c = 0; c < 5; c++) begin
          active[s][c] <= (c == 0) ? COEF_ONE : '0;
          shadow[s][c] <= (c == 0) ? COEF_ONE : '0;
        end
      end
    end else begin
      bus.out_valid    <= 1'b0;
      bus.coef_updated <= copy;

      // The copy reads the shadow bank before this cycle's write lands.
      if (copy) active <= shadow;
      if (bus.coef_we && (bus.coef_sel < 3'd5) && (32'(bus.coef_stage) < STAGES))
        shadow[bus.coef_stage][bus.coef_sel] <= bus.coef_data;

      if (bus.coef_commit && ((state == MAC) || (state == WB)))
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.state_clear) begin
            for (int s = 0; s < STAGES; s++) begin
              x1[s] <= '0;
              x2[s] <= '0;
              y1[s] <= '0;
              y2[s] <= '0;
            end
          end
          if (accept) begin
            stage <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (k == 3'd4) state <= WB;
          else           k     <= k + 3'd1;
        end
        WB: begin
          x1[stage] <= xcur;
          x2[stage] <= x1[stage];
          y1[stage] <= r;
          y2[stage] <= y1[stage];
          k         <= '0;
          if (stage == LAST) begin
            state <= DONE;
          end else begin
            stage <= stage + SW'(1);
            state <= MAC;
          end
        end
        DONE: begin
          bus.sample_out <= xcur;
          bus.out_valid  <= 1'b1;
          pending        <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- datapath: stage input and accumulator ----
  always_ff @(posedge Clk) begin
    if (accept)
      xcur <= bus.sample_in;
    else if (state == WB)
      xcur <= r;
    if (state == MAC)
      acc <= ((k == 3'd0) ? '0 : acc) + ACC_W'(prod);
  end
endmodule

// File: tb/tb_biquad_cascade.sv
module tb_biquad_cascade;
  localparam int DATA_W = 16;
  localparam int COEF_W = 18;
  localparam int FRAC_W = 14;
  localparam int STAGES = 4;
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int LAT    = 6 * STAGES + 1;
  localparam longint ONE  = longint'(1) << FRAC_W;
  localparam longint HALF = longint'(1) << (FRAC_W - 1);
  localparam longint MODV = longint'(1) << DATA_W;
  localparam longint DMAX = (longint'(1) << (DATA_W - 1)) - 1;
  localparam longint DMIN = -(longint'(1) << (DATA_W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  biquad_cascade_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .STAGES(STAGES)) bus ();

  biquad_cascade #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .STAGES(STAGES)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint val;
    int     acc_cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: active/shadow banks and per-stage histories.
  longint mb [STAGES][5];
  longint ms [STAGES][5];
  longint hx1 [STAGES];
  longint hx2 [STAGES];
  longint hy1 [STAGES];
  longint hy2 [STAGES];
  bit     m_pending;

  task automatic check(string name, longint act, longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint floor_div(longint n, longint d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic longint fit(longint v);
    longint w;
`ifdef BIQUAD_CASCADE_SAT_EN
    if (v > DMAX) return DMAX;
    if (v < DMIN) return DMIN;
    return v;
`else
    w = v % MODV;
    if (w < 0) w += MODV;
    if (w > DMAX) w -= MODV;
    return w;
`endif
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < STAGES; s++) begin
      hx1[s] = 0; hx2[s] = 0; hy1[s] = 0; hy2[s] = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < STAGES; s++)
      for (int c = 0; c < 5; c++) begin
        mb[s][c] = (c == 0) ? ONE : 0;
        ms[s][c] = (c == 0) ? ONE : 0;
      end
    model_clear();
    m_pending = 0;
  endfunction

  function automatic longint model_step(longint xin);
    longint x, acc, r;
    x = xin;
    for (int s = 0; s < STAGES; s++) begin
      acc = mb[s][0] * x + mb[s][1] * hx1[s] + mb[s][2] * hx2[s]
          + mb[s][3] * hy1[s] + mb[s][4] * hy2[s];
      r = fit(floor_div(acc + HALF, ONE));
      hx2[s] = hx1[s]; hx1[s] = x;
      hy2[s] = hy1[s]; hy1[s] = r;
      x = r;
    end
    return x;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  longint last_out = 0;
  int     out_cyc  = -1;
  int     upd_cnt  = 0;
  int     upd_cyc  = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_out = bus.sample_out;
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_out: out_valid with no sample outstanding, sample_out=%0d", bus.sample_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample_out", bus.sample_out, mon_e.val);
          check("latency", cyc - mon_e.acc_cyc, LAT);
        end
        out_cyc = cyc;
      end else begin
        check("sample_out_hold", bus.sample_out, last_out);
      end
      last_out = bus.sample_out;
      if (bus.coef_updated) begin
        upd_cnt++;
        upd_cyc = cyc;
      end
    end
  end

  task automatic send(longint x, bit clr);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.sample_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.sample_ready) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: sample_ready stayed %0d, required 1", bus.sample_ready);
      return;
    end
    bus.sample_valid = 1'b1;
    bus.sample_in    = DATA_W'(x);
    bus.state_clear  = clr;
    if (clr) model_clear();
    e.val = model_step(x);
    @(posedge clk);
    #1;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    bus.sample_valid = 1'b0;
    bus.state_clear  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL result_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    if (m_pending) begin
      mb = ms;
      m_pending = 0;
    end
  endtask

  task automatic write_coef(int s, int sel, longint v);
    @(negedge clk);
    bus.coef_we    = 1'b1;
    bus.coef_stage = SW'(s);
    bus.coef_sel   = 3'(sel);
    bus.coef_data  = COEF_W'(v);
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
    if (sel < 5) ms[s][sel] = v;
  endtask

  // Commit while idle, optionally with a simultaneous shadow write.
  task automatic commit_idle(bit with_wr, int s, int sel, longint v);
    @(negedge clk);
    bus.coef_commit = 1'b1;
    mb = ms;
    if (with_wr) begin
      bus.coef_we    = 1'b1;
      bus.coef_stage = SW'(s);
      bus.coef_sel   = 3'(sel);
      bus.coef_data  = COEF_W'(v);
      if (sel < 5) ms[s][sel] = v;
    end
    @(posedge clk);
    #1;
    bus.coef_commit = 1'b0;
    bus.coef_we     = 1'b0;
    @(negedge clk);
    check("coef_updated_idle", bus.coef_updated, 1);
    @(negedge clk);
    check("coef_updated_pulse", bus.coef_updated, 0);
  endtask

  task automatic busy_commit();
    @(negedge clk);
    bus.coef_commit = 1'b1;
    @(posedge clk);
    #1;
    bus.coef_commit = 1'b0;
    m_pending = 1;
  endtask

  task automatic clear_idle();
    @(negedge clk);
    bus.state_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.state_clear = 1'b0;
    model_clear();
  endtask

  function automatic longint rnd(int mag);
    return longint'($urandom_range(0, 2 * mag)) - longint'(mag);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.coef_we      = 1'b0;
    bus.coef_stage   = '0;
    bus.coef_sel     = '0;
    bus.coef_data    = '0;
    bus.coef_commit  = 1'b0;
    bus.state_clear  = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("ready_in_reset", bus.sample_ready, 0);
    check("out_valid_in_reset", bus.out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("sample_out_reset", bus.sample_out, 0);
    check("coef_updated_reset", bus.coef_updated, 0);
    check("ready_after_reset", bus.sample_ready, 1);

    // Pass-through, back-to-back
    send(1234, 0);
    send(-32768, 0);
    wait_idle();
    check("passthru_min", bus.sample_out, -32768);

    // Gain 0.5 and round-half-up
    write_coef(0, 0, 8192);
    commit_idle(0, 0, 0, 0);
    send(1000, 0);
    send(3, 0);
    wait_idle();
    check("gain_round_pos", bus.sample_out, 2);
    send(-3, 0);
    wait_idle();
    check("gain_round_neg", bus.sample_out, -1);

    // Recursion; commit coincides with a shadow write (b0 -> 0.25 in shadow only)
    write_coef(0, 0, 16384);
    write_coef(0, 3, 8192);
    commit_idle(1, 0, 0, 4096);
    send(1000, 1);
    send(0, 0);
    send(0, 0);
    send(0, 0);
    wait_idle();
    check("recursion_tail", bus.sample_out, 125);

    // Clear in IDLE restarts the response; clear while busy is ignored
    clear_idle();
    send(1000, 0);
    wait_idle();
    check("clear_restart", bus.sample_out, 1000);
    send(0, 0);
    @(negedge clk);
    bus.state_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.state_clear = 1'b0;
    wait_idle();
    check("clear_busy_ignored", bus.sample_out, 500);

    // Overflow: b0 = 2.0, a1 = 0
    write_coef(0, 0, 32768);
    write_coef(0, 3, 0);
    commit_idle(0, 0, 0, 0);
    clear_idle();
    send(30000, 0);
    wait_idle();
`ifdef BIQUAD_CASCADE_SAT_EN
    check("overflow", bus.sample_out, 32767);
`else
    check("overflow", bus.sample_out, -5536);
`endif

    // Deferred commit, two requests while busy collapse into one copy
    write_coef(0, 0, 8192);
    u0 = upd_cnt;
    send(100, 0);
    repeat (2) @(negedge clk);
    busy_commit();
    repeat (5) @(negedge clk);
    busy_commit();
    wait_idle();
    check("deferred_old_bank", bus.sample_out, 200);
    check("deferred_update_count", upd_cnt - u0, 1);
    check("deferred_update_timing", ((out_cyc - upd_cyc) >= 0 && (out_cyc - upd_cyc) <= 1) ? 1 : 0, 1);
    send(100, 0);
    wait_idle();
    check("deferred_new_bank", bus.sample_out, 50);

    // Randomized coefficients and samples across all stages
    for (int round = 0; round < 3; round++) begin
      for (int s = 0; s < STAGES; s++) begin
        write_coef(s, 0, rnd(1 << FRAC_W));
        write_coef(s, 1, rnd(1 << (FRAC_W - 1)));
        write_coef(s, 2, rnd(1 << (FRAC_W - 1)));
        write_coef(s, 3, rnd(1 << (FRAC_W - 1)));
        write_coef(s, 4, rnd(1 << (FRAC_W - 2)));
      end
      write_coef(int'($urandom_range(0, STAGES - 1)), int'($urandom_range(5, 7)), rnd(1 << (COEF_W - 2)));
      commit_idle(0, 0, 0, 0);
      for (int i = 0; i < 16; i++)
        send(longint'($urandom_range(0, (1 << DATA_W) - 1)) + DMIN, (i == 0) ? 1'b1 : 1'b0);
      wait_idle();
    end

    // Reset mid-MAC with a commit pending: aborted, pending dropped
    write_coef(1, 1, 5000);
    send(777, 0);
    repeat (2) @(negedge clk);
    busy_commit();
    u0 = upd_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("ready_mid_reset", bus.sample_ready, 0);
    @(negedge clk);
    exp_q.delete();
    model_reset();
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_update_after_abort", upd_cnt - u0, 0);
    check("sample_out_after_abort", bus.sample_out, 0);
    send(1234, 0);
    send(-77, 0);
    wait_idle();
    check("passthru_restored", bus.sample_out, -77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/biquad_cascade.md
# biquad_cascade

Parametrised, time-multiplexed cascade of STAGES direct-form-I biquad sections for the parametric equalizer datapath. A single shared multiplier-accumulator serves every coefficient of every stage. Coefficients are written into a shadow bank and committed atomically between samples, so a filter retune never mixes old and new coefficients within one sample. Samples enter and leave through a valid/ready handshake.

## Interface
- DATA_W, 16: sample width, signed two's complement
- COEF_W, 18: coefficient width, signed
- FRAC_W, 14: coefficient fraction bits; 1.0 = 1 << FRAC_W
- STAGES, 4: number of cascaded biquad sections, 1..16
- Clk  in  1  single clock; all logic on rising edge
- Reset_n  in  1  synchronous, active-low reset
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  block can accept a sample
- sample_in  in  DATA_W  input sample
- sample_out  out  DATA_W  last computed output; held between results
- out_valid  out  1  one-cycle pulse when sample_out updates
- coef_we  in  1  write coef_data into the shadow bank
- coef_stage  in  $clog2(STAGES) (min 1)  target stage
- coef_sel  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; values 5-7 are ignored
- coef_data  in  COEF_W  coefficient value
- coef_commit  in  1  request a shadow-to-active copy
- coef_updated  out  1  one-cycle pulse when the copy happens
- state_clear  in  1  zero all x/y histories; honoured only in IDLE

## Operation
- Per-stage recurrence: y = b0·x + b1·x1 + b2·x2 + a1·y1 + a2·y2. The a-terms are added; the sign convention belongs to the coefficient generator.
- Product width is DATA_W+COEF_W. The accumulator is ACC_W = DATA_W+COEF_W+3 bits, sign-extended, and is cleared at the start of each stage.
- Writeback: r = (acc + 2^(FRAC_W-1)) >>> FRAC_W, which is round-half-up. r is then reduced to DATA_W bits as described in Configuration.
- The output of stage s is the input x of stage s+1. The output of the last stage drives sample_out.
- State machine:
  - IDLE:
    - sample_ready=1.
    - A handshake captures sample_in, sets stage=0 and k=0, and moves to MAC.
  - MAC:
    - One product per cycle, in order b0·x, b1·x1, b2·x2, a1·y1, a2·y2 (k=0..4).
    - After k=4, move to WB.
  - WB:
    - Compute r and shift histories: x2←x1, x1←x, y2←y1, y1←r.
    - If the current stage is the last, move to DONE; otherwise increment stage and return to MAC.
  - DONE:
    - Load sample_out and pulse out_valid.
    - If a commit is pending, perform it this cycle. In all cases return to IDLE.
- Coefficient handling:
  - coef_we writes the shadow bank in any state.
  - coef_commit in IDLE copies the whole shadow bank to the active bank on the next edge and pulses coef_updated with the copy.
  - coef_commit outside IDLE sets a pending flag, which is serviced in DONE.
  - Multiple commits while busy collapse into one.
- If coef_we and the copy happen in the same cycle, the copy takes the pre-write shadow value. The new write lands in the shadow bank only.
- state_clear in IDLE zeroes every history on the next edge. If it coincides with a sample handshake, the clear is applied first and the sample is processed against zero history. state_clear outside IDLE is ignored.
- Reset values:
  - Active and shadow banks: b0 = 1<<FRAC_W, all other coefficients 0 (pass-through).
  - All histories 0; state IDLE.
  - sample_out=0, out_valid=0, coef_updated=0, pending flag 0.
  - sample_ready=0 while Reset_n=0.
- Reset asserted mid-computation aborts the sample. No out_valid is produced, and any pending commit is discarded.

## Timing
- Each stage takes 6 cycles: 5 MAC plus 1 WB.
- out_valid is high in the cycle 6·STAGES+1 edges after the accepting edge (25 for STAGES=4).
- sample_ready is low from the accepting edge until DONE returns to IDLE. Maximum throughput is one sample per 6·STAGES+2 cycles.
- sample_out changes only in DONE.
- coef_updated goes high on the edge after an IDLE commit, or in the DONE cycle for a pending commit.

## Configuration
- BIQUAD_CASCADE_SAT_EN defined: r is saturated to the DATA_W range. With DATA_W=16 that is [-32768, 32767]. Saturation is applied at every stage.
- BIQUAD_CASCADE_SAT_EN undefined: r is truncated to its low DATA_W bits (two's-complement wrap). No saturation logic is instantiated.

## Test plan
- Pass-through: release reset, send 1234 → sample_out=1234 with out_valid 25 cycles after acceptance. Send -32768 → output -32768.
- Gain and rounding:
  - Write stage0 b0=0.5 (8192) and commit, expect coef_updated pulse.
  - Inputs 1000, 3, -3 → outputs 500, 2, -1.
- Recursion: set stage0 a1=0.5. Impulse 1000 then zeros → outputs 1000, 500, 250, 125.
- Overflow:
  - Set b0=2.0 (32768) on stage0, input 30000.
  - SAT_EN: output 32767.
  - Without SAT_EN: output -5536.
- Deferred commit:
  - Write new coefficients, then assert coef_commit 3 cycles after a sample is accepted.
  - That sample uses the old bank; coef_updated pulses in DONE; the next sample uses the new bank.
- Reset and clear:
  - Assert Reset_n=0 mid-MAC → no out_valid, pass-through restored.
  - state_clear in IDLE after recursion → next impulse response restarts from zero history.
